// File: rtl/tcp_event_sched.sv
// Event scheduler and SYN/FIN retransmit / TIME_WAIT timer in front of the TCP connection FSM.
// Grants at most one source (rx segment or app command) per cycle and turns it into FSM input pulses.
module tcp_event_sched #(
  parameter int RETX_CYCLES = 1000,
  parameter int TW_CYCLES   = 4000,
  parameter int MAX_RETRY   = 3,
  parameter int CNT_W       = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       app_valid,
  input  logic [1:0] app_cmd,
  output logic       app_ready,
  input  logic       rx_valid,
  input  logic [3:0] rx_flags,
  output logic       rx_ready,
  output logic       a_opn,
  output logic       p_opn,
  output logic       cls,
  output logic       send_data,
  output logic       SYN_i,
  output logic       ACK_i,
  output logic       FIN_i,
  output logic       RST_i,
  output logic       timo_strb,
  input  logic       SYN_o,
  input  logic       ACK_o,
  input  logic       FIN_o,
  input  logic       RST_o,
  output logic       retx_o,
  output logic       retx_fin_o
);

  localparam int RET_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
  localparam logic [CNT_W-1:0] RETX_LOAD = CNT_W'(RETX_CYCLES - 1);
  localparam logic [CNT_W-1:0] TW_LOAD   = CNT_W'(TW_CYCLES - 1);
  localparam logic [RET_W-1:0] RETRY_MAX = RET_W'(MAX_RETRY);

  // rx_flags bit positions: {SYN,ACK,FIN,RST}
  localparam int F_ACK = 2;
  localparam int F_FIN = 1;
  localparam int F_RST = 0;

  localparam logic [1:0] CMD_CLS = 2'd2;

  typedef enum logic [1:0] {IDLE, RETX, TW, TIMO_PEND} mode_e;

  mode_e              mode_q, mode_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [RET_W-1:0]   retries_q, retries_d;
  logic               fin_q, fin_d;
  logic               ptr_app_q, ptr_app_d;
  logic               grant_rx, grant_app;
  logic               retx_fire;
  logic               fsm_busy;
  logic               rx_rst, rx_fin, rx_ack, app_cls;

  // State register
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples the same pre-edge values.
    if (rst) begin
      mode_q    <= IDLE;
      cnt_q     <= '0;
      retries_q <= '0;
      fin_q     <= 1'b0;
      ptr_app_q <= 1'b0;
    end else begin
      mode_q    <= mode_d;
      cnt_q     <= cnt_d;
      retries_q <= retries_d;
      fin_q     <= fin_d;
      ptr_app_q <= ptr_app_d;
    end
  end

  // Arbitration: a pending timeout blocks both sources, otherwise round-robin.
  always_comb begin
    // NOTE: every comb output gets a default first so no path infers a latch.
    grant_rx  = 1'b0;
    grant_app = 1'b0;
    if (!rst && mode_q != TIMO_PEND) begin
      if (ptr_app_q) begin
        grant_app = app_valid;
        grant_rx  = rx_valid & ~app_valid;
      end else begin
        grant_rx  = rx_valid;
        grant_app = app_valid & ~rx_valid;
      end
    end
  end

  assign fsm_busy = SYN_o | ACK_o | FIN_o | RST_o;
  assign rx_rst   = grant_rx & rx_flags[F_RST];
  assign rx_fin   = grant_rx & rx_flags[F_FIN];
  assign rx_ack   = grant_rx & rx_flags[F_ACK];
  assign app_cls  = grant_app & (app_cmd == CMD_CLS);

  // Next-state: timer rules in strict priority order, so a reload always beats an expiry.
  always_comb begin
    mode_d    = mode_q;
    cnt_d     = cnt_q;
    retries_d = retries_q;
    fin_d     = fin_q;
    retx_fire = 1'b0;
    ptr_app_d = ptr_app_q;
    if (grant_rx)       ptr_app_d = 1'b1;
    else if (grant_app) ptr_app_d = 1'b0;

    if (RST_o || rx_rst) begin
      mode_d    = IDLE;
      retries_d = '0;
    end else if (SYN_o || FIN_o) begin
      mode_d    = RETX;
      cnt_d     = RETX_LOAD;
      retries_d = '0;
      fin_d     = FIN_o;
    end else if (ACK_o && rx_fin) begin
      mode_d = TW;
      cnt_d  = TW_LOAD;
    end else if (rx_ack && mode_q == RETX) begin
      mode_d    = IDLE;
      retries_d = '0;
    end else if (app_cls && !fsm_busy && mode_q == RETX) begin
      mode_d = IDLE;
    end else if (mode_q == RETX && cnt_q == '0) begin
      if (retries_q < RETRY_MAX) begin
        retx_fire = 1'b1;
        retries_d = retries_q + RET_W'(1);
        cnt_d     = RETX_LOAD;
      end else begin
        mode_d = TIMO_PEND;
      end
    end else if (mode_q == TW && cnt_q == '0) begin
      mode_d = TIMO_PEND;
    end else if (mode_q == TIMO_PEND) begin
      mode_d    = IDLE;
      retries_d = '0;
    end else if (mode_q == RETX || mode_q == TW) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  // Outputs. timo_strb depends on state only, so the FSM's same-cycle reaction cannot loop back.
  always_comb begin
    app_ready  = grant_app;
    rx_ready   = grant_rx;
    a_opn      = grant_app & (app_cmd == 2'd0);
    p_opn      = grant_app & (app_cmd == 2'd1);
    cls        = app_cls;
    send_data  = grant_app & (app_cmd == 2'd3);
    {SYN_i, ACK_i, FIN_i, RST_i} = grant_rx ? rx_flags : 4'b0000;
    timo_strb  = ~rst & (mode_q == TIMO_PEND);
    retx_o     = ~rst & retx_fire;
    retx_fin_o = ~rst & retx_fire & fin_q;
  end

endmodule
